// File: rtl/wb_arb_pkg.sv
// Shared constants for the Wishbone two-master arbiter.
// Arbiter state encodings and Wishbone cycle-type codes.
package wb_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_GNT0 = 2'd1;
  localparam arb_state_t ARB_GNT1 = 2'd2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts stalled strobe cycles, pulses tmo_o at LIMIT-1.
// Ports: clk, rst (sync high), en (owner stb), term (any slave
// termination), clr (grant change) -> tmo_o (one-cycle timeout pulse).
module wb_arb_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic term,
  input  logic clr,
  output logic tmo_o
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tmo_o = en & ~term & (cnt_q == LAST);

  // Restart after the pulse so a persisting strobe gets a fresh window.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!en || term || clr || tmo_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arb2_rr.sv
// Two-master Wishbone B3 round-robin arbiter onto one slave port.
// Ports: wb_clk_i/wb_rst_i (sync high); m0_*/m1_* master buses in/out;
// s_* slave bus; grant_o one-hot owner {m1,m0}, 00 when idle.
// Optional stall watchdog enabled by defining WB_ARB2_TIMEOUT_EN.
module wb_arb2_rr
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,

  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,

  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,

  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,

  output logic [1:0]      grant_o
);

  arb_state_t state_q, state_d;
  // 1 = m1 was served last, so m0 wins the next tie.
  logic       last_q, last_d;

  logic gnt0;
  logic gnt1;
  logic own_stb;
  logic term;
  logic tmo;

  assign gnt0    = (state_q == ARB_GNT0);
  assign gnt1    = (state_q == ARB_GNT1);
  assign grant_o = {gnt1, gnt0};
  assign own_stb = (gnt0 & m0_stb_i) | (gnt1 & m1_stb_i);
  assign term    = s_ack_i | s_err_i | s_rty_i;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_GNT0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
        end
      end
      ARB_GNT1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? ARB_GNT0 : ARB_GNT1;
        end else if (m0_cyc_i) begin
          state_d = ARB_GNT0;
        end else if (m1_cyc_i) begin
          state_d = ARB_GNT1;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_ARB2_TIMEOUT_EN
  wb_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .en    (own_stb),
    .term  (term),
    .clr   (state_d != state_q),
    .tmo_o (tmo)
  );
`else
  logic unused_wdog;
  assign unused_wdog = own_stb ^ term ^ (TIMEOUT_CYCLES != 0);
  assign tmo = 1'b0;
`endif

  // Read data fans out to both; the gated ack keeps the loser blind.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    unique case (1'b1)
      gnt0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~tmo;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | tmo;
        m0_rty_o = s_rty_i;
      end
      gnt1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~tmo;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | tmo;
        m1_rty_o = s_rty_i;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arb2_rr.sv
// Directed bench for wb_arb2_rr: arbitration table plus corner cases.
// Reset, rotation, burst hold, write passthrough, watchdog, mid-reset.
module tb_wb_arb2_rr;

  localparam int AW = 32;
  localparam int DW = 32;

`ifdef WB_ARB2_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [AW-1:0]   m0_adr, m1_adr;
  logic [DW-1:0]   m0_dat, m1_dat;
  logic [DW/8-1:0] m0_sel, m1_sel;
  logic            m0_we, m1_we;
  logic            m0_cyc, m1_cyc;
  logic            m0_stb, m1_stb;
  logic [2:0]      m0_cti, m1_cti;
  logic [1:0]      m0_bte, m1_bte;
  logic [DW-1:0]   m0_rdat, m1_rdat;
  logic            m0_ack, m0_err, m0_rty;
  logic            m1_ack, m1_err, m1_rty;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_wdat;
  logic [DW/8-1:0] s_sel;
  logic            s_we, s_cyc, s_stb;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic [DW-1:0]   s_rdat;
  logic            s_ack, s_err, s_rty;
  logic [1:0]      grant;

  int n_chk;
  int n_pass;

  wb_arb2_rr #(
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0_adr_i (m0_adr),
    .m0_dat_i (m0_dat),
    .m0_sel_i (m0_sel),
    .m0_we_i  (m0_we),
    .m0_cyc_i (m0_cyc),
    .m0_stb_i (m0_stb),
    .m0_cti_i (m0_cti),
    .m0_bte_i (m0_bte),
    .m0_dat_o (m0_rdat),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m0_rty_o (m0_rty),
    .m1_adr_i (m1_adr),
    .m1_dat_i (m1_dat),
    .m1_sel_i (m1_sel),
    .m1_we_i  (m1_we),
    .m1_cyc_i (m1_cyc),
    .m1_stb_i (m1_stb),
    .m1_cti_i (m1_cti),
    .m1_bte_i (m1_bte),
    .m1_dat_o (m1_rdat),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .m1_rty_o (m1_rty),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_wdat),
    .s_sel_o  (s_sel),
    .s_we_o   (s_we),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_cti_o  (s_cti),
    .s_bte_o  (s_bte),
    .s_dat_i  (s_rdat),
    .s_ack_i  (s_ack),
    .s_err_i  (s_err),
    .s_rty_i  (s_rty),
    .grant_o  (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       c0;
    logic       c1;
    logic       ack;
    logic [1:0] gnt;
    logic       scyc;
    logic       a0;
    logic       a1;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  // Advance one clock; everything after returns 1ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int i, input logic c0, input logic c1,
                         input logic ack, input logic [1:0] gnt,
                         input logic scyc, input logic a0,
                         input logic a1);
    tbl[i].c0   = c0;
    tbl[i].c1   = c1;
    tbl[i].ack  = ack;
    tbl[i].gnt  = gnt;
    tbl[i].scyc = scyc;
    tbl[i].a0   = a0;
    tbl[i].a1   = a1;
  endtask

  int n_err;
  int first_err;
  logic stb_at_err;

  initial begin
    n_chk  = 0;
    n_pass = 0;

    set_row(0,  0, 0, 0, 2'b00, 0, 0, 0);
    set_row(1,  1, 1, 0, 2'b01, 1, 0, 0);
    set_row(2,  1, 1, 1, 2'b01, 1, 1, 0);
    set_row(3,  0, 1, 0, 2'b10, 1, 0, 0);
    set_row(4,  1, 1, 1, 2'b10, 1, 0, 1);
    set_row(5,  1, 0, 0, 2'b01, 1, 0, 0);
    set_row(6,  0, 0, 1, 2'b00, 0, 0, 0);
    set_row(7,  1, 1, 0, 2'b10, 1, 0, 0);
    set_row(8,  0, 1, 1, 2'b10, 1, 0, 1);
    set_row(9,  0, 0, 0, 2'b00, 0, 0, 0);
    set_row(10, 0, 1, 0, 2'b10, 1, 0, 0);
    set_row(11, 0, 0, 1, 2'b00, 0, 0, 0);
    set_row(12, 1, 0, 0, 2'b01, 1, 0, 0);
    set_row(13, 0, 0, 0, 2'b00, 0, 0, 0);
    set_row(14, 1, 1, 0, 2'b10, 1, 0, 0);
    set_row(15, 1, 0, 1, 2'b01, 1, 1, 0);
    set_row(16, 1, 1, 0, 2'b01, 1, 0, 0);
    set_row(17, 0, 0, 0, 2'b00, 0, 0, 0);

    m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 0;
    m0_cyc = 0;  m0_stb = 0;  m0_cti = '0; m0_bte = '0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 0;
    m1_cyc = 0;  m1_stb = 0;  m1_cti = '0; m1_bte = '0;
    s_rdat = 32'h1234_5678;
    s_ack = 0; s_err = 0; s_rty = 0;

    // Reset held with both requesting and slave terminations high.
    rst = 1;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    s_ack = 1; s_err = 1; s_rty = 1;
    step();
    step();
    chk("rst_grant", grant, 2'b00);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_sstb", s_stb, 0);
    chk("rst_term", {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}, 0);
    chk("rst_sadr", s_adr, 0);
    s_ack = 0; s_err = 0; s_rty = 0;
    rst = 0;
    step();
    chk("rst_first_gnt", grant, 2'b01);

    // Fresh reset for the arbitration table.
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    rst = 1;
    step();
    rst = 0;

    for (int i = 0; i < 18; i++) begin
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].c0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].c1;
      s_ack  = tbl[i].ack;
      step();
      chk($sformatf("tbl%0d_gnt", i), grant, tbl[i].gnt);
      chk($sformatf("tbl%0d_scyc", i), s_cyc, tbl[i].scyc);
      chk($sformatf("tbl%0d_ack0", i), m0_ack, tbl[i].a0);
      chk($sformatf("tbl%0d_ack1", i), m1_ack, tbl[i].a1);
    end
    s_ack = 0;

    // m1 single write passthrough.
    m1_adr = 32'h44; m1_dat = 32'hDEAD_BEEF; m1_sel = 4'b0011;
    m1_we = 1; m1_cyc = 1; m1_stb = 1;
    step();
    chk("wr_grant", grant, 2'b10);
    chk("wr_adr", s_adr, 32'h44);
    chk("wr_dat", s_wdat, 32'hDEAD_BEEF);
    chk("wr_sel", s_sel, 4'b0011);
    chk("wr_we", s_we, 1);
    chk("wr_ack_lo", m1_ack, 0);
    s_ack = 1;
    #1;
    chk("wr_ack_hi", m1_ack, 1);
    chk("wr_ack_m0", m0_ack, 0);
    s_err = 1; s_ack = 0;
    #1;
    chk("wr_err", {m1_err, m0_err}, 2'b10);
    s_err = 0;
    s_rdat = 32'hCAFE_F00D;
    #1;
    chk("rd_dat", {m0_rdat, m1_rdat}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    step();
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    step();
    chk("wr_idle_gnt", grant, 2'b00);
    chk("wr_idle_adr", s_adr, 0);

    // m0 4-beat incrementing burst while m1 waits.
    m0_adr = 32'h100; m0_cti = 3'b010; m0_bte = 2'b00;
    m0_cyc = 1; m0_stb = 1;
    step();
    chk("bst_gnt0", grant, 2'b01);
    m1_adr = 32'h200; m1_cti = 3'b010; m1_we = 0;
    m1_cyc = 1; m1_stb = 1;
    for (int b = 0; b < 4; b++) begin
      m0_adr = 32'h100 + 32'(4 * b);
      m0_cti = (b == 3) ? 3'b111 : 3'b010;
      s_ack = 1;
      #1;
      chk($sformatf("bst%0d_gnt", b), grant, 2'b01);
      chk($sformatf("bst%0d_adr", b), s_adr, 32'h100 + 32'(4 * b));
      chk($sformatf("bst%0d_cti", b), s_cti, (b == 3) ? 3'b111 : 3'b010);
      chk($sformatf("bst%0d_ack", b), {m1_ack, m0_ack}, 2'b01);
      step();
    end
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #1;
    chk("bst_rel_gnt", grant, 2'b01);
    chk("bst_rel_ack1", m1_ack, 0);
    step();
    chk("bst_hand_gnt", grant, 2'b10);
    chk("bst_hand_adr", s_adr, 32'h200);

    // Reset during beat 2 of an m1 burst.
    s_ack = 1;
    step();
    m1_adr = 32'h204;
    rst = 1;
    step();
    chk("mrst_gnt", grant, 2'b00);
    chk("mrst_scyc", s_cyc, 0);
    chk("mrst_ack1", m1_ack, 0);
    s_ack = 0;
    m0_cyc = 1; m0_stb = 1;
    rst = 0;
    step();
    chk("mrst_after_gnt", grant, 2'b01);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    step();
    chk("mrst_idle", grant, 2'b00);

    // m0 stalls against a slave that never terminates.
    n_err = 0;
    first_err = 0;
    stb_at_err = 1'b0;
    m0_adr = 32'h300; m0_cti = 3'b000;
    m0_cyc = 1; m0_stb = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (m0_err) begin
        n_err++;
        if (first_err == 0) begin
          first_err  = i;
          stb_at_err = s_stb;
        end
        m0_cyc = 0;
        m0_stb = 0;
      end
    end
    chk("tmo_count", 64'(n_err), TMO_ON ? 64'd1 : 64'd0);
    chk("tmo_cycle", 64'(first_err), TMO_ON ? 64'd8 : 64'd0);
    chk("tmo_stb", stb_at_err, 0);
    chk("tmo_m1_err", m1_err, 0);
    m0_cyc = 0; m0_stb = 0;
    step();
    chk("tmo_end_gnt", grant, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_arb2_rr.md
# wb_arb2_rr

Two-master, one-slave Wishbone B3 round-robin arbiter. It shares a single slave port, typically the system SRAM, between the CPU instruction master (iwbm) and data master (dwbm). It sits between the masters and the bus matrix slave port. Each master holds the grant for its whole cycle, bursts included, and requests are served in round-robin order. An optional watchdog terminates stalled transfers with an error.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (sel width = DW/8)
- TIMEOUT_CYCLES, 255, watchdog stall limit in cycles (only used with the watchdog macro; range 2..65535)

Ports:
- wb_clk_i  in  1  system clock; everything synchronous to its rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- m0_adr_i / m1_adr_i  in  AW  master address
- m0_dat_i / m1_dat_i  in  DW  master write data
- m0_sel_i / m1_sel_i  in  DW/8  byte selects
- m0_we_i, m0_cyc_i, m0_stb_i / m1_*  in  1 each  write enable, cycle, strobe
- m0_cti_i / m1_cti_i  in  3  cycle type; m0_bte_i / m1_bte_i  in  2  burst type
- m0_dat_o / m1_dat_o  out  DW  read data
- m0_ack_o, m0_err_o, m0_rty_o / m1_*  out  1 each  termination
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  out  slave side of the above
- s_dat_i, s_ack_i, s_err_i, s_rty_i  in  slave responses
- grant_o  out  2  one-hot current owner ({m1,m0}); 2'b00 when idle

## Operation
- States: IDLE, GNT0, GNT1. Encoding is registered; grant_o is decoded from the state.
- IDLE: if exactly one mN_cyc_i is high, go to GNTN. If both are high, grant the master that was not last served. The last-served pointer resets to m1, so m0 wins the first tie.
- GNTn: s_* outputs = master n signals. mn_ack/err/rty_o = s_ack/err/rty_i. The other master sees ack/err/rty = 0.
- Both mN_dat_o = s_dat_i at all times; this is harmless because ack is gated.
- Release: when mn_cyc_i = 0 in GNTn, update the pointer to n.
  - If the other master's cyc is high, go directly to its GNT state (no idle bubble).
  - Otherwise go to IDLE.
- The grant is never revoked while the owner's cyc is high, including across cti=3'b010 bursts and cyc held between strobes.
- Idle/reset slave outputs: s_cyc_o, s_stb_o, s_we_o = 0. s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o = 0 (the mux is gated by grant).
- Reset asserted mid-transfer aborts it: state goes to IDLE, the pointer goes to m1, and all outputs take reset values on the next edge. No termination is issued to the master.

## Timing
- Request latency: cyc rises at edge N in IDLE → s_cyc_o/s_stb_o high after edge N+1 (1 cycle).
- Handover: owner drops cyc at cycle K → the other master is on the slave bus from cycle K+1.
- Responses are combinational pass-through, adding 0 cycles to slave latency.
- Simultaneous release and new request from the same master: the other master, if requesting, takes the grant first (fairness).
- err/rty from the slave are passed through unchanged and do not release the grant. Only cyc low releases it.

## Configuration
- WB_ARB2_TIMEOUT_EN defined:
  - In GNTn, a 16-bit counter increments each cycle the owner's stb is high and none of s_ack_i/s_err_i/s_rty_i is high. It clears on any termination, on stb low, and on a state change.
  - When the counter equals TIMEOUT_CYCLES-1, mn_err_o pulses high for 1 cycle and s_stb_o is forced low that cycle. The counter then clears.
  - The grant is kept until the master drops cyc.
- Not defined: no counter is built, stalls wait forever, and the TIMEOUT_CYCLES parameter is ignored.

## Structure
- Shared package wb_arb_pkg holds:
  - state encodings ARB_IDLE=2'd0, ARB_GNT0=2'd1, ARB_GNT1=2'd2
  - Wishbone CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111
- One sub-module wb_arb_watchdog: counter plus compare producing a one-cycle timeout pulse. It is instantiated only under WB_ARB2_TIMEOUT_EN.

## Test plan
- Reset: hold wb_rst_i 2 cycles with both cyc high → grant_o=00, s_cyc_o=0, all terminations 0. First edge after release → grant_o=01.
- Tie rotation: both masters issue back-to-back single reads to addresses 0x10 and 0x20 → grants alternate 01,10,01,10 with no idle cycle between owners; each master gets its own ack count only.
- Burst hold: m0 does a 4-beat cti=010/111 read from 0x100 while m1 requests → m1 is granted only on the cycle after m0 cyc drops; m1_ack_o stays 0 throughout m0's burst.
- Write passthrough: m1 writes 0xDEADBEEF with sel=4'b0011 to 0x44 → s_dat_o, s_sel_o, s_adr_o match on the same cycle, and m1_ack_o mirrors s_ack_i.
- Timeout (macro on, TIMEOUT_CYCLES=8): slave never acks → m0_err_o pulses exactly once, 8 cycles after stb rises, with s_stb_o=0 that cycle. Macro off → no err ever.
- Mid-burst reset: assert wb_rst_i during beat 2 of an m1 burst → next cycle grant_o=00, s_cyc_o=0. After release with both requesting → m0 granted.
